// File: rtl/apa102_frame_tx.sv
// APA102 frame serializer: streams a 32-bit start frame, eight LED words and a
// 32-bit end frame on mosi/sclk, repeating while write_data is held high.
module apa102_frame_tx #(
    parameter int         CLK_DIV    = 5,
    parameter logic [4:0] BRIGHTNESS = 5'h1F
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [63:0] led_r_vector,
    input  logic [63:0] led_g_vector,
    input  logic [63:0] led_b_vector,
    input  logic        write_data,
    output logic        mosi,
    output logic        sclk,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        START_FRAME,
        LED_FRAME,
        END_FRAME
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_next;
    logic [7:0]  div_cnt, div_next;
    logic [4:0]  bit_idx, bit_next;
    logic [3:0]  word_idx, word_next;
    logic        sclk_next, mosi_next, busy_next, done_next;
    logic        load, advance;
    logic [31:0] word_val;
    logic [63:0] shadow_r, shadow_g, shadow_b;

    // Next-state logic: word 0 is the start frame, words 1..8 the LEDs, word 9
    // the end frame. mosi is registered and only updated when a low phase begins.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_idx;
        word_next  = word_idx;
        sclk_next  = sclk;
        mosi_next  = mosi;
        busy_next  = busy;
        done_next  = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        word_val   = '0;

        case (state)
            IDLE: begin
                sclk_next = 1'b0;
                mosi_next = 1'b0;
                busy_next = 1'b0;
                div_next  = '0;
                bit_next  = '0;
                word_next = '0;
                if (write_data) begin
                    load       = 1'b1;
                    state_next = START_FRAME;
                    busy_next  = 1'b1;
                end
            end
            default: begin
                if (div_cnt == DIV_LAST) begin
                    div_next = '0;
                    if (!sclk) begin
                        sclk_next = 1'b1;
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_idx == 5'd31 && word_idx == 4'd9) begin
                            state_next = IDLE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                            mosi_next  = 1'b0;
                            bit_next   = '0;
                            word_next  = '0;
                        end else begin
                            advance = 1'b1;
                            if (bit_idx == 5'd31) begin
                                bit_next  = '0;
                                word_next = word_idx + 4'd1;
                            end else begin
                                bit_next = bit_idx + 5'd1;
                            end
                        end
                    end
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
        endcase

        if (word_next == 4'd9) begin
            word_val = '1;
        end
        for (int i = 0; i < 8; i++) begin
            if (word_next == 4'(i + 1)) begin
                word_val = {3'b111, BRIGHTNESS, shadow_b[8*i +: 8],
                            shadow_g[8*i +: 8], shadow_r[8*i +: 8]};
            end
        end

        if (advance) begin
            mosi_next = word_val[5'd31 - bit_next];
            if (word_next == 4'd9) begin
                state_next = END_FRAME;
            end else if (word_next != 4'd0) begin
                state_next = LED_FRAME;
            end else begin
                state_next = START_FRAME;
            end
        end
    end

    // State, counters, outputs and colour shadows; reset abandons any frame.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_idx    <= '0;
            word_idx   <= '0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shadow_r   <= '0;
            shadow_g   <= '0;
            shadow_b   <= '0;
        end else begin
            state      <= state_next;
            div_cnt    <= div_next;
            bit_idx    <= bit_next;
            word_idx   <= word_next;
            sclk       <= sclk_next;
            mosi       <= mosi_next;
            busy       <= busy_next;
            frame_done <= done_next;
            if (load) begin
                shadow_r <= led_r_vector;
                shadow_g <= led_g_vector;
                shadow_b <= led_b_vector;
            end
        end
    end

endmodule

// File: tb/tb_apa102_frame_tx.sv
// Bench for apa102_frame_tx: two instances (CLK_DIV=5 and CLK_DIV=1), a
// frame-level reference model feeding a scoreboard, and a decoding monitor.
module tb_apa102_frame_tx;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [63:0] led_r, led_g, led_b;
    logic [1:0]  wd;
    logic [1:0]  mosi_w, sclk_w, busy_w, done_w;

    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    // 100 MHz board clock
    always #5 sys_clk = ~sys_clk;

    // Cycle counter used for frame timing
    initial forever begin
        @(posedge sys_clk);
        cycle = cycle + 1;
    end

    apa102_frame_tx #(.CLK_DIV(5), .BRIGHTNESS(5'h1F)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .led_r_vector(led_r), .led_g_vector(led_g), .led_b_vector(led_b),
        .write_data(wd[0]), .mosi(mosi_w[0]), .sclk(sclk_w[0]),
        .busy(busy_w[0]), .frame_done(done_w[0])
    );

    apa102_frame_tx #(.CLK_DIV(1), .BRIGHTNESS(5'h1F)) dut1 (
        .sys_clk(sys_clk), .rst(rst),
        .led_r_vector(led_r), .led_g_vector(led_g), .led_b_vector(led_b),
        .write_data(wd[1]), .mosi(mosi_w[1]), .sclk(sclk_w[1]),
        .busy(busy_w[1]), .frame_done(done_w[1])
    );

    // Expected 320-bit frame, first transmitted bit in bit 319
    function automatic logic [319:0] ref_frame(input logic [63:0] r, input logic [63:0] g,
                                               input logic [63:0] b);
        logic [319:0] f;
        f = '0;
        f[31:0] = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            f[287 - 32*i -: 32] = {3'b111, 5'h1F, b[8*i +: 8], g[8*i +: 8], r[8*i +: 8]};
        end
        return f;
    endfunction

    task automatic check_output(input int lane, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act === exp) begin
            passes = passes + 1;
        end else begin
            $display("[TB] FAIL lane%0d %s: got %0h, expected %0h at cycle %0d",
                     lane, name, act, exp, cycle);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : lane
        localparam int D = (gi == 0) ? 5 : 1;
        logic [319:0] exp_q[$];
        int           left = 0;
        logic         exp_done = 1'b0;
        logic [319:0] cap = '0;
        int           nbits = 0;
        logic         prev_sclk = 1'b0;
        logic [319:0] last_frame = '0;
        int           last_done = 0;

        // Reference model: a frame starts whenever the block is idle and
        // write_data is high, then occupies 640*CLK_DIV cycles.
        initial forever begin
            @(posedge sys_clk or posedge rst);
            if (rst) begin
                left     = 0;
                exp_done = 1'b0;
                exp_q.delete();
            end else begin
                exp_done = 1'b0;
                if (left == 0) begin
                    if (wd[gi]) begin
                        exp_q.push_back(ref_frame(led_r, led_g, led_b));
                        left = 640 * D;
                    end
                end else begin
                    left = left - 1;
                    if (left == 0) exp_done = 1'b1;
                end
            end
        end

        // Monitor: decodes mosi on sclk rising edges and scores each frame
        initial forever begin
            @(negedge sys_clk);
            if (rst) begin
                nbits     = 0;
                cap       = '0;
                prev_sclk = 1'b0;
            end else begin
                check_output(gi, "busy", 64'(busy_w[gi]), 64'(left > 0));
                check_output(gi, "frame_done", 64'(done_w[gi]), 64'(exp_done));
                if (left == 0) begin
                    check_output(gi, "idle_sclk", 64'(sclk_w[gi]), 64'd0);
                    check_output(gi, "idle_mosi", 64'(mosi_w[gi]), 64'd0);
                end
                if (sclk_w[gi] && !prev_sclk) begin
                    cap   = {cap[318:0], mosi_w[gi]};
                    nbits = nbits + 1;
                end
                prev_sclk = sclk_w[gi];
                if (done_w[gi]) begin
                    check_output(gi, "queue_depth", 64'(exp_q.size()), 64'd1);
                    if (exp_q.size() > 0) begin
                        logic [319:0] e;
                        e = exp_q.pop_front();
                        check_output(gi, "bit_count", 64'(nbits), 64'd320);
                        for (int k = 0; k < 10; k++) begin
                            check_output(gi, $sformatf("word%0d", k),
                                         64'(cap[319 - 32*k -: 32]), 64'(e[319 - 32*k -: 32]));
                        end
                    end
                    last_frame = cap;
                    last_done  = cycle;
                    nbits      = 0;
                    cap        = '0;
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [63:0] r, input logic [63:0] g,
                                  input logic [63:0] b);
        led_r = r;
        led_g = g;
        led_b = b;
    endtask

    // Waits for the next frame_done of a lane, bounded by a cycle budget
    task automatic wait_done(input int which, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n = n + 1;
        end while (done_w[which] !== 1'b1 && n < budget);
        if (done_w[which] !== 1'b1) begin
            checks = checks + 1;
            $display("[TB] FAIL lane%0d done_timeout: no frame_done within %0d cycles",
                     which, budget);
        end
        #1;
    endtask

    int           latch_t, t1, t2, t3;
    logic [319:0] f;

    // Directed scenarios followed by randomized frames on both lanes
    initial begin
        rst = 1'b1;
        wd  = 2'b00;
        apply_stimulus('0, '0, '0);
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            check_output(l, "reset_mosi", 64'(mosi_w[l]), 64'd0);
            check_output(l, "reset_sclk", 64'(sclk_w[l]), 64'd0);
            check_output(l, "reset_busy", 64'(busy_w[l]), 64'd0);
            check_output(l, "reset_done", 64'(done_w[l]), 64'd0);
        end
        repeat (5000) @(negedge sys_clk);

        $display("[TB] single frame, CLK_DIV=5");
        apply_stimulus(64'h40, 64'h0, 64'h80);
        wd[0] = 1'b1;
        @(negedge sys_clk);
        wd[0] = 1'b0;
        latch_t = cycle;
        wait_done(0, 4000);
        check_output(0, "single_latency", 64'(lane[0].last_done - latch_t), 64'd3200);
        f = lane[0].last_frame;
        check_output(0, "single_start", 64'(f[319:288]), 64'h0);
        check_output(0, "single_word0", 64'(f[287:256]), 64'hFF80_0040);
        check_output(0, "single_word7", 64'(f[63:32]), 64'hFF00_0000);
        check_output(0, "single_end", 64'(f[31:0]), 64'hFFFF_FFFF);

        $display("[TB] continuous mode with mid-frame vector changes");
        apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        wd[0] = 1'b1;
        repeat (1000) @(negedge sys_clk);
        led_r = '1;
        wait_done(0, 4000);
        t1 = lane[0].last_done;
        repeat (500) @(negedge sys_clk);
        led_g = {$urandom, $urandom};
        led_b = {$urandom, $urandom};
        wait_done(0, 4000);
        t2 = lane[0].last_done;
        f  = lane[0].last_frame;
        check_output(0, "shadow_r_led0", 64'(f[263:256]), 64'hFF);
        check_output(0, "shadow_r_led7", 64'(f[39:32]), 64'hFF);
        @(negedge sys_clk);
        wd[0] = 1'b0;
        wait_done(0, 4000);
        t3 = lane[0].last_done;
        check_output(0, "period_1_2", 64'(t2 - t1), 64'd3201);
        check_output(0, "period_2_3", 64'(t3 - t2), 64'd3201);
        repeat (4000) @(negedge sys_clk);

        $display("[TB] reset mid-frame");
        apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        wd[0] = 1'b1;
        @(negedge sys_clk);
        wd[0] = 1'b0;
        repeat (1700) @(negedge sys_clk);
        @(posedge sys_clk);
        #1 rst = 1'b1;
        #1;
        check_output(0, "midreset_mosi", 64'(mosi_w[0]), 64'd0);
        check_output(0, "midreset_sclk", 64'(sclk_w[0]), 64'd0);
        check_output(0, "midreset_busy", 64'(busy_w[0]), 64'd0);
        check_output(0, "midreset_done", 64'(done_w[0]), 64'd0);
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        wd[0] = 1'b1;
        @(negedge sys_clk);
        wd[0] = 1'b0;
        wait_done(0, 4000);
        f = lane[0].last_frame;
        check_output(0, "postreset_start", 64'(f[319:288]), 64'h0);

        $display("[TB] single frame, CLK_DIV=1");
        apply_stimulus(64'h40, 64'h0, 64'h80);
        wd[1] = 1'b1;
        @(negedge sys_clk);
        wd[1] = 1'b0;
        latch_t = cycle;
        wait_done(1, 1000);
        check_output(1, "single_latency", 64'(lane[1].last_done - latch_t), 64'd640);
        f = lane[1].last_frame;
        check_output(1, "single_word0", 64'(f[287:256]), 64'hFF80_0040);
        check_output(1, "single_word3", 64'(f[191:160]), 64'hFF00_0000);

        $display("[TB] randomized frames");
        for (int it = 0; it < 4; it++) begin
            apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            wd = 2'b11;
            repeat ($urandom_range(1, 3)) @(negedge sys_clk);
            wd = 2'b00;
            repeat ($urandom_range(10, 600)) @(negedge sys_clk);
            apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            wait_done(0, 4000);
            repeat (5) @(negedge sys_clk);
        end

        for (int l = 0; l < 2; l++) begin
            check_output(l, "queue_drained", 64'(l == 0 ? lane[0].exp_q.size()
                                                        : lane[1].exp_q.size()), 64'd0);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/apa102_frame_tx.md
Name: apa102_frame_tx

Overview:
- Serializer stage directly downstream of the POV display state machine.
- Takes the 8-LED RGB pixel column (three 64-bit colour vectors plus the write_data level) and streams it as an APA102 two-wire frame on mosi/sclk (JA1/JA2).
- One complete frame refreshes all 8 LEDs.
- While write_data is held high, frames repeat back to back, resampling the colour vectors at each frame start.

Parameters:
- CLK_DIV, 5, sys_clk cycles per sclk half-period; legal range 1..255; default gives 10 MHz sclk from 100 MHz.
- BRIGHTNESS, 5'h1F, 5-bit global brightness field sent in every LED frame.

Ports:
- sys_clk  in  1  system clock (100 MHz board clock)
- rst  in  1  asynchronous, active-high reset
- led_r_vector  in  64  red bytes; LED i = bits [8i+7:8i]
- led_g_vector  in  64  green bytes, same packing
- led_b_vector  in  64  blue bytes, same packing
- write_data  in  1  level; high = transmit frames continuously
- mosi  out  1  serial data to LED strip
- sclk  out  1  serial clock to LED strip; idles low
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (async, immediate, also mid-frame):
  - state=IDLE; sclk=0, mosi=0, busy=0, frame_done=0.
  - All counters cleared; shadow registers cleared.
  - Partial frame is abandoned, not completed.
- States: IDLE, START_FRAME, LED_FRAME, END_FRAME.
- IDLE:
  - sclk=0, mosi=0, busy=0.
  - On a sys_clk edge with write_data=1: latch all three vectors into shadow registers, go to START_FRAME, busy=1 from the next cycle.
- Bit timing, every bit in every state:
  - Low phase: CLK_DIV cycles, sclk=0, mosi=bit value.
  - High phase: CLK_DIV cycles, sclk=1, mosi held.
  - mosi changes only at the start of a low phase; the strip samples on the sclk rising edge.
- START_FRAME: 32 bits of 0.
- LED_FRAME:
  - 8 words, LED 0 first.
  - Each word, MSB first: 3'b111, BRIGHTNESS[4:0], B[7:0], G[7:0], R[7:0], all taken from the shadow registers.
- END_FRAME: 32 bits of 1.
- Frame length: 320 bits = 640*CLK_DIV cycles (3200 at default).
- Frame end:
  - At the edge ending the final high phase: state=IDLE, sclk=0, mosi=0, busy=0, frame_done=1 for exactly that cycle.
  - IDLE then evaluates write_data on the next edge, so the frame-to-frame period is 640*CLK_DIV+1 cycles when write_data stays high.
- Input changes mid-frame:
  - Vector changes have no effect on the frame in flight; they are picked up only at the next IDLE latch.
  - write_data falling mid-frame does not abort; the current frame completes, then the block stays in IDLE.
- Counters:
  - 8-bit divide counter, 5-bit bit index, 4-bit word index (0..9).
  - Wrap exactly at their terminal counts; no other arithmetic.
- A write_data pulse of one cycle in IDLE is sufficient to send exactly one frame.

Test Plan:
- Reset values: assert rst mid-simulation -> mosi=0, sclk=0, busy=0, frame_done=0 within the same cycle; hold write_data=0 for 5000 cycles -> no sclk edges.
- Single frame: LED0 R=8'h40 G=8'h00 B=8'h80, others 0; pulse write_data 1 cycle -> decoder sees exactly 320 rising edges:
  - 32 zeros
  - word0 = 32'hFF800040
  - words1..7 = 32'hFF000000
  - 32 ones
  - frame_done at cycle 3200 after the latch edge.
- Shadowing: change led_r_vector to all 8'hFF at bit 100 of a frame -> current frame unchanged; with write_data held high, next frame carries FF in every R byte.
- Continuous mode: hold write_data=1 for 3 frames -> frame_done pulses spaced 3201 cycles apart; busy low for exactly 1 cycle between frames.
- Reset mid-frame: assert rst at LED word 4 -> outputs return to idle immediately; after release with write_data=1, the new frame starts with the 32-zero start frame.
- CLK_DIV=1: single frame -> sclk toggles every cycle, 640-cycle frame, same decoded bits as the single-frame scenario.
